// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg: shared encodings for the DDR-port BRAM responder.
//   - ATYPE_WR / ATYPE_RD     : combined address channel direction bit
//   - BURST_FIXED / BURST_INCR: burst type encodings
//   - RESP_OKAY / RESP_SLVERR : B/R response codes
//   - state_t                 : responder FSM states
//   - BEAT_BYTES              : bytes per 128-bit beat
package ddr_axi_pkg;

  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic       ATYPE_RD    = 1'b0;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BEAT_BYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_sdp_be.sv
// bram_sdp_be: simple dual-port RAM, byte-enabled write port, registered
// read port with read enable.
//   clk, rst_n   : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata/wbe : write port, one enable bit per byte lane
//   re/raddr     : read request; rdata updates one cycle after re=1
//   rdata        : read register, holds its value while re=0
// Memory contents are never cleared.
module bram_sdp_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Holding rdata when re=0 is what keeps RDATA stable during an R stall.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddr_axi_bram_responder.sv
// ddr_axi_bram_responder: responder end of the DdrCtrl_*_0 port backed by an
// on-chip BRAM. One burst at a time; combined A channel, W, B and R channels.
//   Axi_Clk / Axi_Rst_N       : clock, synchronous active-low reset
//   DdrCtrl_A*_0              : address channel (ATYPE 1=write, 0=read)
//   DdrCtrl_W*_0              : write data; burst length comes from ALEN only
//   DdrCtrl_B*_0              : write response
//   DdrCtrl_R*_0              : read data, registered, full throughput
//   resp_err                  : sticky protocol-error flag
//   state_dbg                 : current FSM state (state_t encoding)
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; a source holds VALID and its payload until then.
// Optional feature macro: DDR_RESP_ERR_CHK_EN (WLAST/ASIZE checking, SLVERR).
module ddr_axi_bram_responder
  import ddr_axi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 128
) (
  input  logic                Axi_Clk,
  input  logic                Axi_Rst_N,
  input  logic [31:0]         DdrCtrl_AADDR_0,
  input  logic                DdrCtrl_ATYPE_0,
  input  logic [7:0]          DdrCtrl_AID_0,
  input  logic [7:0]          DdrCtrl_ALEN_0,
  input  logic [2:0]          DdrCtrl_ASIZE_0,
  input  logic [1:0]          DdrCtrl_ABURST_0,
  input  logic [1:0]          DdrCtrl_ALOCK_0,
  input  logic                DdrCtrl_AVALID_0,
  output logic                DdrCtrl_AREADY_0,
  input  logic [DATA_W-1:0]   DdrCtrl_WDATA_0,
  input  logic [DATA_W/8-1:0] DdrCtrl_WSTRB_0,
  input  logic [7:0]          DdrCtrl_WID_0,
  input  logic                DdrCtrl_WLAST_0,
  input  logic                DdrCtrl_WVALID_0,
  output logic                DdrCtrl_WREADY_0,
  output logic [7:0]          DdrCtrl_BID_0,
  output logic [1:0]          DdrCtrl_BRESP_0,
  output logic                DdrCtrl_BVALID_0,
  input  logic                DdrCtrl_BREADY_0,
  output logic [DATA_W-1:0]   DdrCtrl_RDATA_0,
  output logic [7:0]          DdrCtrl_RID_0,
  output logic [1:0]          DdrCtrl_RRESP_0,
  output logic                DdrCtrl_RLAST_0,
  output logic                DdrCtrl_RVALID_0,
  input  logic                DdrCtrl_RREADY_0,
  output logic                resp_err,
  output logic [1:0]          state_dbg
);

  state_t                state, state_nx;
  logic                  aready_q, wready_c, bvalid_c;
  logic [7:0]            a_id, a_len;
  logic [DEPTH_LOG2-1:0] addr, addr_step;
  logic                  fixed;
  logic [8:0]            cnt;       // 9 bits so "all 256 beats issued" is representable
  logic                  err_q, resp_err_q;
  logic                  rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic                  a_hs, w_beat, w_final, rd_issue, r_done;
  logic                  size_bad, wlast_bad;

  assign a_hs      = aready_q && DdrCtrl_AVALID_0;
  assign w_beat    = (state == ST_WRITE) && DdrCtrl_WVALID_0;
  assign w_final   = w_beat && (cnt[7:0] == a_len);
  assign rd_issue  = (state == ST_READ) && (!rvalid_q || DdrCtrl_RREADY_0)
                     && (cnt <= {1'b0, a_len});
  assign r_done    = (state == ST_READ) && rvalid_q && DdrCtrl_RREADY_0 && rlast_q;
  assign addr_step = fixed ? addr : addr + DEPTH_LOG2'(1);

`ifdef DDR_RESP_ERR_CHK_EN
  // WLAST must coincide exactly with the ALEN-th beat; early or missing both count.
  assign size_bad  = (DdrCtrl_ASIZE_0 != 3'd4);
  assign wlast_bad = w_beat && (DdrCtrl_WLAST_0 != (cnt[7:0] == a_len));
  logic unused_bits;
  assign unused_bits = ^{DdrCtrl_ALOCK_0, DdrCtrl_WID_0,
                         DdrCtrl_AADDR_0[31:4+DEPTH_LOG2], DdrCtrl_AADDR_0[3:0]};
`else
  assign size_bad  = 1'b0;
  assign wlast_bad = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{DdrCtrl_ALOCK_0, DdrCtrl_WID_0, DdrCtrl_ASIZE_0,
                         DdrCtrl_WLAST_0,
                         DdrCtrl_AADDR_0[31:4+DEPTH_LOG2], DdrCtrl_AADDR_0[3:0]};
`endif

  always_comb begin
    state_nx = state;
    wready_c = 1'b0;
    bvalid_c = 1'b0;
    unique case (state)
      ST_IDLE:  if (a_hs) state_nx = (DdrCtrl_ATYPE_0 == ATYPE_WR) ? ST_WRITE : ST_READ;
      ST_WRITE: begin
        wready_c = 1'b1;
        if (w_final) state_nx = ST_WRESP;
      end
      ST_WRESP: begin
        bvalid_c = 1'b1;
        if (DdrCtrl_BREADY_0) state_nx = ST_IDLE;
      end
      ST_READ:  if (r_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Axi_Clk) begin
    if (!Axi_Rst_N) begin
      state      <= ST_IDLE;
      aready_q   <= 1'b0;
      a_id       <= '0;
      a_len      <= '0;
      addr       <= '0;
      fixed      <= 1'b0;
      cnt        <= '0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      resp_err_q <= 1'b0;
    end else begin
      state    <= state_nx;
      // Registered so AREADY stays low through reset and rises one cycle later.
      aready_q <= (state_nx == ST_IDLE);
      if (a_hs) begin
        a_id  <= DdrCtrl_AID_0;
        a_len <= DdrCtrl_ALEN_0;
        addr  <= DdrCtrl_AADDR_0[4+DEPTH_LOG2-1:4];
        fixed <= (DdrCtrl_ABURST_0 == BURST_FIXED);
        cnt   <= '0;
        err_q <= size_bad;
      end
      // Write beats and read issues share the counter and address pointer.
      if (w_beat || rd_issue) begin
        cnt  <= cnt + 9'd1;
        addr <= addr_step;
      end
      if (wlast_bad) err_q <= 1'b1;
      if (rd_issue) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (cnt[7:0] == a_len);
        rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && DdrCtrl_RREADY_0) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
      resp_err_q <= resp_err_q | (a_hs && size_bad) | wlast_bad;
    end
  end

  bram_sdp_be #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W)) u_bram (
    .clk   (Axi_Clk),
    .rst_n (Axi_Rst_N),
    .we    (w_beat),
    .waddr (addr),
    .wdata (DdrCtrl_WDATA_0),
    .wbe   (DdrCtrl_WSTRB_0),
    .re    (rd_issue),
    .raddr (addr),
    .rdata (DdrCtrl_RDATA_0)
  );

  assign DdrCtrl_AREADY_0 = aready_q;
  assign DdrCtrl_WREADY_0 = wready_c;
  assign DdrCtrl_BVALID_0 = bvalid_c;
  assign DdrCtrl_BID_0    = a_id;
  assign DdrCtrl_BRESP_0  = (bvalid_c && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign DdrCtrl_RVALID_0 = rvalid_q;
  assign DdrCtrl_RLAST_0  = rlast_q;
  assign DdrCtrl_RID_0    = a_id;
  assign DdrCtrl_RRESP_0  = rresp_q;
  assign resp_err         = resp_err_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_ddr_axi_bram_responder.sv
// tb_ddr_axi_bram_responder: directed bench for ddr_axi_bram_responder.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected read data is queued in exp_q.
module tb_ddr_axi_bram_responder;
  import ddr_axi_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  aaddr = '0;
  logic         atype = 1'b0;
  logic [7:0]   aid = '0, alen = '0;
  logic [2:0]   asize = 3'd4;
  logic [1:0]   aburst = BURST_INCR, alock = '0;
  logic         avalid = 1'b0, aready;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic [7:0]   wid = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, wready;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready = 1'b0;
  logic [127:0] rdata;
  logic [7:0]   rid;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready = 1'b0;
  logic         resp_err;
  logic [1:0]   state_dbg;

  int           total = 0;
  int           bad = 0;
  logic [127:0] exp_q[$];
  logic [127:0] wbeats[16];

`ifdef DDR_RESP_ERR_CHK_EN
  localparam logic [1:0] ERR_BRESP = 2'b10;
  localparam logic       ERR_FLAG  = 1'b1;
`else
  localparam logic [1:0] ERR_BRESP = 2'b00;
  localparam logic       ERR_FLAG  = 1'b0;
`endif

  ddr_axi_bram_responder dut (
    .Axi_Clk(clk), .Axi_Rst_N(rst_n),
    .DdrCtrl_AADDR_0(aaddr), .DdrCtrl_ATYPE_0(atype), .DdrCtrl_AID_0(aid),
    .DdrCtrl_ALEN_0(alen), .DdrCtrl_ASIZE_0(asize), .DdrCtrl_ABURST_0(aburst),
    .DdrCtrl_ALOCK_0(alock), .DdrCtrl_AVALID_0(avalid), .DdrCtrl_AREADY_0(aready),
    .DdrCtrl_WDATA_0(wdata), .DdrCtrl_WSTRB_0(wstrb), .DdrCtrl_WID_0(wid),
    .DdrCtrl_WLAST_0(wlast), .DdrCtrl_WVALID_0(wvalid), .DdrCtrl_WREADY_0(wready),
    .DdrCtrl_BID_0(bid), .DdrCtrl_BRESP_0(bresp), .DdrCtrl_BVALID_0(bvalid),
    .DdrCtrl_BREADY_0(bready),
    .DdrCtrl_RDATA_0(rdata), .DdrCtrl_RID_0(rid), .DdrCtrl_RRESP_0(rresp),
    .DdrCtrl_RLAST_0(rlast), .DdrCtrl_RVALID_0(rvalid), .DdrCtrl_RREADY_0(rready),
    .resp_err(resp_err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // driver tasks (entered and left on a falling edge)
  task automatic send_addr(input logic typ, input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
    int n;
    aaddr = addr; atype = typ; aid = id; alen = len; aburst = burst; asize = 3'd4;
    avalid = 1'b1;
    n = 0;
    while (!aready && n < 20) begin @(negedge clk); n++; end
    if (!aready) timeout_fail("a_handshake");
    @(negedge clk);
    avalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id, input logic [15:0] strb, input int last_at,
                          input logic [1:0] exp_resp);
    int n;
    send_addr(ATYPE_WR, addr, id, len, burst);
    check("w_ready_first", wready, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbeats[i]; wstrb = strb; wlast = (i == last_at);
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      if (!wready) timeout_fail("w_handshake");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid_latency", bvalid, 1'b1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) timeout_fail("b_handshake");
    check("b_id", bid, id);
    check("b_resp", bresp, exp_resp);
    @(negedge clk);
    bready = 1'b0;
    check("a_ready_after_b", aready, 1'b1);
  endtask

  // mode 0: RREADY held high; mode 1: RREADY pattern 1,0,0,1 repeating.
  // abort_at > 0: reset the DUT right after that many beats were seen.
  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id, input int mode, input int abort_at);
    int beat, cyc;
    logic done, aborted, stalled;
    logic [127:0] held, e;
    logic [3:0] pat;
    pat = 4'b1001;
    beat = 0; cyc = 0; done = 1'b0; aborted = 1'b0; stalled = 1'b0; held = '0;
    rready = 1'b0;
    send_addr(ATYPE_RD, addr, id, len, burst);
    check("r_valid_early", rvalid, 1'b0);
    while (!done && cyc < 200) begin
      @(negedge clk);
      rready = (mode == 1) ? pat[cyc % 4] : 1'b1;
      if (cyc == 0) check("r_first_valid", rvalid, 1'b1);
      if (stalled && rvalid) check("r_stall_hold", rdata, held);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) timeout_fail("r_exp_empty");
        else begin
          e = exp_q.pop_front();
          check("r_data", rdata, e);
        end
        check("r_last", rlast, (beat == int'(len)));
        check("r_id", rid, id);
        beat++;
        stalled = 1'b0;
        if (beat == int'(len) + 1) done = 1'b1;
        if (abort_at != 0 && beat == abort_at) begin
          rst_n = 1'b0; rready = 1'b0;
          @(negedge clk);
          check("abort_rvalid", rvalid, 1'b0);
          check("abort_state", state_dbg, ST_IDLE);
          check("abort_aready", aready, 1'b0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check("abort_aready_back", aready, 1'b1);
          exp_q.delete();
          done = 1'b1; aborted = 1'b1;
        end
      end else begin
        stalled = rvalid;
        held = rdata;
      end
      cyc++;
    end
    if (!done) timeout_fail("r_burst");
    if (!aborted) begin
      @(negedge clk);
      rready = 1'b0;
      check("a_ready_after_r", aready, 1'b1);
    end
  endtask

  // directed sequence
  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_aready", aready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rdata", rdata, 128'h0);
    check("rst_rid", rid, 8'h00);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("aready_after_rst", aready, 1'b1);

    // write 4 beats at 0x100 then read back
    wbeats[0] = 128'h0100_0000_0000_0000_0000_0000_0000_0001;
    wbeats[1] = 128'h0200_0000_0000_0000_0000_0000_0000_0002;
    wbeats[2] = 128'h0300_0000_0000_0000_0000_0000_0000_0003;
    wbeats[3] = 128'h0400_0000_0000_0000_0000_0000_0000_0004;
    wr_burst(32'h0000_0100, 8'd3, BURST_INCR, 8'h5A, 16'hFFFF, 3, 2'b00);
    exp_q.push_back(128'h0100_0000_0000_0000_0000_0000_0000_0001);
    exp_q.push_back(128'h0200_0000_0000_0000_0000_0000_0000_0002);
    exp_q.push_back(128'h0300_0000_0000_0000_0000_0000_0000_0003);
    exp_q.push_back(128'h0400_0000_0000_0000_0000_0000_0000_0004);
    rd_burst(32'h0000_0100, 8'd3, BURST_INCR, 8'h3C, 0, 0);

    // byte strobes at word 5
    wbeats[0] = {128{1'b1}};
    wr_burst(32'h0000_0050, 8'd0, BURST_INCR, 8'h01, 16'hFFFF, 0, 2'b00);
    wbeats[0] = 128'h0;
    wr_burst(32'h0000_0050, 8'd0, BURST_INCR, 8'h02, 16'h000F, 0, 2'b00);
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);
    rd_burst(32'h0000_0050, 8'd0, BURST_INCR, 8'h03, 0, 0);

    // 8-beat read under RREADY backpressure, words 32..39
    for (int i = 0; i < 8; i++) wbeats[i] = {96'hCAFE_0000_0000_0000_0000_0000, 32'(i + 1)};
    wr_burst(32'h0000_0200, 8'd7, BURST_INCR, 8'h10, 16'hFFFF, 7, 2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back({96'hCAFE_0000_0000_0000_0000_0000, 32'(i + 1)});
    rd_burst(32'h0000_0200, 8'd7, BURST_INCR, 8'h11, 1, 0);

    // INCR wrap: last word (1023) then word 0; upper address bits ignored
    wbeats[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_AAAA;
    wbeats[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB;
    wr_burst(32'h8000_3FF0, 8'd1, BURST_INCR, 8'h20, 16'hFFFF, 1, 2'b00);
    exp_q.push_back(128'hAAAA_0000_0000_0000_0000_0000_0000_AAAA);
    rd_burst(32'h0000_3FF0, 8'd0, BURST_INCR, 8'h21, 0, 0);
    exp_q.push_back(128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB);
    rd_burst(32'h0000_0000, 8'd0, BURST_INCR, 8'h22, 0, 0);

    // FIXED write at word 8; word 9 must stay untouched
    wbeats[0] = 128'h9999_0000_0000_0000_0000_0000_0000_9999;
    wr_burst(32'h0000_0090, 8'd0, BURST_INCR, 8'h30, 16'hFFFF, 0, 2'b00);
    wbeats[0] = 128'hC1;
    wbeats[1] = 128'hC2;
    wbeats[2] = 128'hC3;
    wr_burst(32'h0000_0080, 8'd2, BURST_FIXED, 8'h31, 16'hFFFF, 2, 2'b00);
    exp_q.push_back(128'hC3);
    exp_q.push_back(128'h9999_0000_0000_0000_0000_0000_0000_9999);
    rd_burst(32'h0000_0080, 8'd1, BURST_INCR, 8'h32, 0, 0);
    exp_q.push_back(128'hC3);
    exp_q.push_back(128'hC3);
    rd_burst(32'h0000_0080, 8'd1, BURST_FIXED, 8'h33, 0, 0);

    // reset after beat 2 of 8, then a clean re-read
    for (int i = 0; i < 8; i++) exp_q.push_back({96'hCAFE_0000_0000_0000_0000_0000, 32'(i + 1)});
    rd_burst(32'h0000_0200, 8'd7, BURST_INCR, 8'h40, 0, 2);
    for (int i = 0; i < 8; i++) exp_q.push_back({96'hCAFE_0000_0000_0000_0000_0000, 32'(i + 1)});
    rd_burst(32'h0000_0200, 8'd7, BURST_INCR, 8'h41, 0, 0);

    // early WLAST on beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) wbeats[i] = 128'(32'hE000 + i);
    wr_burst(32'h0000_0400, 8'd3, BURST_INCR, 8'h50, 16'hFFFF, 1, ERR_BRESP);
    check("err_flag", resp_err, ERR_FLAG);
    wbeats[0] = 128'h0;
    wr_burst(32'h0000_0400, 8'd0, BURST_INCR, 8'h51, 16'hFFFF, 0, 2'b00);
    check("err_flag_sticky", resp_err, ERR_FLAG);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
